riscv_dmem_responder: RTL
=========================

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 The block SHALL have parameter DEPTH_BIT, default 10, meaning log2 of storage depth in 32-bit words.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait cycles per access, legal range 0..15.
REQ-004 The block SHALL have port i_clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port i_dmem_req, input, 1, meaning the initiator requests an access; held high until o_dmem_ready is seen.
REQ-007 The block SHALL have port i_dmem_addr, input, XLEN, meaning the byte address; word index is addr[DEPTH_BIT+1:2].
REQ-008 The block SHALL have port i_dmem_wr_en, input, 1, meaning write (1) or read (0).
REQ-009 The block SHALL have port i_dmem_byte_sel, input, 4, meaning byte-lane enables for writes; bit n selects bits [8n+7:8n].
REQ-010 The block SHALL have port i_dmem_wr_data, input, XLEN, meaning lane-aligned write data.
REQ-011 The block SHALL have port o_dmem_ready, output, 1, meaning a one-cycle pulse marking transaction completion.
REQ-012 The block SHALL have port o_dmem_rd_data, output, XLEN, meaning the full read word, valid while o_dmem_ready is high.
REQ-013 The block SHALL have port o_dmem_err, output, 1, meaning the access failed, valid while o_dmem_ready is high.

Function
REQ-014 The block SHALL implement three states: IDLE, WAIT and RESP.
REQ-015 IDLE SHALL capture addr, wr_en, byte_sel and wr_data at the edge on which i_dmem_req=1, then go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-016 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to RESP at the edge on which it reads 0.
REQ-017 RESP SHALL drive o_dmem_ready=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-018 A request SHALL NOT be accepted in WAIT or RESP, so at least one IDLE cycle separates transactions.
REQ-019 Latency from the request-sampling edge to ready high SHALL be WAIT_CYCLES+1 cycles.
REQ-020 Writes SHALL update only the selected byte lanes, at the edge entering RESP; byte_sel=4'b0000 SHALL complete normally with no change.
REQ-021 Reads SHALL register the full word into o_dmem_rd_data at the edge entering RESP.
REQ-022 A read issued after a completed write to the same word SHALL return the written data.
REQ-023 Request inputs SHALL be ignored after capture; changes during WAIT SHALL have no effect.
REQ-024 o_dmem_rd_data SHALL hold its last value outside RESP, and SHALL be 0 after writes and errored accesses.

Reset
REQ-025 i_rst=1 SHALL immediately force state=IDLE, counter=0, o_dmem_ready=0, o_dmem_err=0 and o_dmem_rd_data=0.
REQ-026 Reset asserted in WAIT SHALL abort the transaction, and its write SHALL NOT be performed.
REQ-027 Reset SHALL NOT clear the storage contents.
REQ-028 The first request SHALL be accepted at the first rising edge after i_rst deasserts.

Configuration
REQ-029 With macro RISCV_DMEM_RESP_ERR_EN defined, an access with any nonzero bit in i_dmem_addr[XLEN-1:DEPTH_BIT+2] SHALL produce o_dmem_err=1 with ready, suppress any write, and return rd_data=0.
REQ-030 With RISCV_DMEM_RESP_ERR_EN undefined, o_dmem_err SHALL be tied to 0 and the upper address bits ignored, so the address wraps modulo 2**DEPTH_BIT words.

Verification
REQ-031 Write 0x1234_5678 to 0x10 with byte_sel=1111, then read 0x10 -> each ready arrives 3 cycles after req; read returns 0x1234_5678 with err=0.
REQ-032 Write 0xAABB_CCDD to word 0x10 (holding 0x1234_5678) with byte_sel=0101, then read -> 0x12BB_56DD.
REQ-033 Assert reset during the second WAIT cycle of a write of 0xFFFF_FFFF to 0x20 -> ready never pulses; a later read of 0x20 returns the prior contents.
REQ-034 With the macro defined and DEPTH_BIT=10, read 0x0000_1000 -> err=1, rd_data=0; without the macro, the same read returns word 0.
REQ-035 Hold req high across back-to-back reads -> ready pulses spaced WAIT_CYCLES+2 cycles apart with no duplicate pulse in RESP.
REQ-036 With WAIT_CYCLES=0, read 0x10 -> ready high in the cycle after the request-sampling edge.

Source files
------------

// File: rtl/riscv_dmem_responder_if.sv
// riscv_dmem_responder_if
// Purpose: groups the data-memory request/response signals between an initiator
//   (master) and the riscv_dmem_responder (slave).
// Signals:
//   i_dmem_req       request strobe, held high by the master until ready is seen
//   i_dmem_addr      byte address (XLEN bits)
//   i_dmem_wr_en     1 = write, 0 = read
//   i_dmem_byte_sel  byte-lane enables for writes
//   i_dmem_wr_data   lane-aligned write data
//   o_dmem_ready     one-cycle completion pulse
//   o_dmem_rd_data   read word, valid with ready
//   o_dmem_err       access error flag, valid with ready
interface riscv_dmem_responder_if #(
  parameter int XLEN = 32
);
  logic            i_dmem_req;
  logic [XLEN-1:0] i_dmem_addr;
  logic            i_dmem_wr_en;
  logic [3:0]      i_dmem_byte_sel;
  logic [XLEN-1:0] i_dmem_wr_data;
  logic            o_dmem_ready;
  logic [XLEN-1:0] o_dmem_rd_data;
  logic            o_dmem_err;

  modport master (
    output i_dmem_req, i_dmem_addr, i_dmem_wr_en, i_dmem_byte_sel, i_dmem_wr_data,
    input  o_dmem_ready, o_dmem_rd_data, o_dmem_err
  );

  modport slave (
    input  i_dmem_req, i_dmem_addr, i_dmem_wr_en, i_dmem_byte_sel, i_dmem_wr_data,
    output o_dmem_ready, o_dmem_rd_data, o_dmem_err
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder
// Purpose: word-organised data memory that answers one request at a time with a
//   fixed, configurable latency (IDLE -> WAIT -> RESP -> IDLE).
// Ports:
//   i_clk  single clock, rising edge
//   i_rst  asynchronous active-high reset (storage contents are preserved)
//   dmem   riscv_dmem_responder_if.slave request/response bundle
// Parameters:
//   XLEN         data/address width
//   DEPTH_BIT    log2 of storage depth in 32-bit words
//   WAIT_CYCLES  extra wait cycles per access (0..15)
// Configuration macro:
//   RISCV_DMEM_RESP_ERR_EN  when defined, addresses with any nonzero bit above the
//   word index complete with o_dmem_err=1, no write and rd_data=0; when undefined
//   the upper bits are ignored and addresses wrap.
module riscv_dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_BIT   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                   i_clk,
  input logic                   i_rst,
  riscv_dmem_responder_if.slave dmem
);

  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;

  logic [XLEN-1:0] cap_addr;
  logic            cap_wr_en;
  logic [3:0]      cap_byte_sel;
  logic [XLEN-1:0] cap_wr_data;

  logic            ready_q;
  logic            err_q;
  logic [XLEN-1:0] rd_data_q;

  logic [XLEN-1:0] mem [DEPTH];

  logic                 enter_resp;
  logic [XLEN-1:0]      acc_addr;
  logic                 acc_wr_en;
  logic [3:0]           acc_byte_sel;
  logic [XLEN-1:0]      acc_wr_data;
  logic [DEPTH_BIT-1:0] acc_idx;
  logic                 acc_err;
  logic                 unused_addr_bits;

  // The access that completes at the edge entering RESP. With zero wait cycles
  // that edge is also the capture edge, so the live request inputs are used;
  // otherwise the captured copy is used and later input changes are ignored.
  always_comb begin
    enter_resp   = 1'b0;
    acc_addr     = cap_addr;
    acc_wr_en    = cap_wr_en;
    acc_byte_sel = cap_byte_sel;
    acc_wr_data  = cap_wr_data;
    if (state == IDLE) begin
      enter_resp   = dmem.i_dmem_req && (WAIT_CYCLES == 0);
      acc_addr     = dmem.i_dmem_addr;
      acc_wr_en    = dmem.i_dmem_wr_en;
      acc_byte_sel = dmem.i_dmem_byte_sel;
      acc_wr_data  = dmem.i_dmem_wr_data;
    end else if (state == WAIT) begin
      enter_resp = (wait_cnt == 4'd0);
    end
  end

  assign acc_idx = acc_addr[DEPTH_BIT+1:2];

`ifdef RISCV_DMEM_RESP_ERR_EN
  assign acc_err = |acc_addr[XLEN-1:DEPTH_BIT+2];
`else
  assign acc_err = 1'b0;
`endif

  assign unused_addr_bits = ^{acc_addr[XLEN-1:DEPTH_BIT+2], acc_addr[1:0]};

  // Control FSM and registered response. Ready is raised on the edge entering
  // RESP and dropped on the edge leaving it, so it is a single-cycle pulse;
  // rd_data only changes on the edge entering RESP and otherwise holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      cap_addr     <= '0;
      cap_wr_en    <= 1'b0;
      cap_byte_sel <= 4'd0;
      cap_wr_data  <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem.i_dmem_req) begin
            cap_addr     <= dmem.i_dmem_addr;
            cap_wr_en    <= dmem.i_dmem_wr_en;
            cap_byte_sel <= dmem.i_dmem_byte_sel;
            cap_wr_data  <= dmem.i_dmem_wr_data;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (enter_resp) begin
        ready_q   <= 1'b1;
        err_q     <= acc_err;
        rd_data_q <= (acc_wr_en || acc_err) ? '0 : mem[acc_idx];
      end
    end
  end

  // Storage has no reset so its contents survive i_rst. The write is gated
  // with i_rst so a reset that overlaps the completing edge aborts it.
  always_ff @(posedge i_clk) begin
    if (enter_resp && acc_wr_en && !acc_err && !i_rst) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_byte_sel[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wr_data[8*b +: 8];
        end
      end
    end
  end

  assign dmem.o_dmem_ready   = ready_q;
  assign dmem.o_dmem_err     = err_q;
  assign dmem.o_dmem_rd_data = rd_data_q;

endmodule
